// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches through a req/ack handshake,
// holds the instruction register and selects the next PC on retire.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  localparam int unsigned XLEN    = 32,
  localparam int unsigned IMM_W   = 16,
  localparam int unsigned JIDX_W  = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_offset,
  input  logic             jump,
  input  logic             jr,
  input  logic [XLEN-1:0]  jr_target,
  output logic             instr_valid,
  output logic [XLEN-1:0]  instr,
  output logic [IMM_W-1:0] imm,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  // The word offset is shifted left by two, so its top two bits never matter.
  logic unused_br_hi;
  assign unused_br_hi = ^br_offset[XLEN-1:XLEN-2];

  // Candidate targets and next-PC selection: jr > jump > branch > sequential.
  always_comb begin
    pc_seq   = pc_q + XLEN'(4);
    jump_tgt = {pc_seq[XLEN-1:XLEN-4], instr_q[JIDX_W-1:0], 2'b00};
    br_tgt   = pc_seq + {br_offset[XLEN-3:0], 2'b00};
    next_pc  = pc_seq;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_tgt;
    end else if (br_taken) begin
      next_pc = br_tgt;
    end
    next_misaligned = (next_pc[1:0] != 2'b00);
  end

  // Next-state and registered-output logic for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        valid_d = 1'b0;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      VALID: begin
        if (!stall) begin
          // Retire: the faulting address is kept in pc but never requested.
          pc_d    = next_pc;
          valid_d = 1'b0;
          if (next_misaligned) begin
            state_d = HALT;
            req_d   = 1'b0;
            fault_d = 1'b1;
          end else begin
            state_d = FETCH;
            req_d   = 1'b1;
          end
        end
      end
      HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign imm         = instr_q[IMM_W-1:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_seq;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized
// instruction stream checked against a next-PC reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = '0;
  logic        jump = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] imm;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_fault;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jr(jr), .jr_target(jr_target),
    .instr_valid(instr_valid), .instr(instr), .imm(imm),
    .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next PC computed directly from the redirect rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic jr_i, input logic [31:0] tgt,
                                           input logic j_i, input logic b_i,
                                           input logic [31:0] off);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (jr_i) return tgt;
    if (j_i)  return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b_i)  return seq + (off * 32'd4);
    return seq;
  endfunction

  task automatic do_reset();
    imem_ack = 1'b0; stall = 1'b0; jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    m_pc = RESET_PC; m_instr = '0; m_fault = 1'b0;
  endtask

  // Fetch at m_pc with a given ack delay, then hold in VALID for some stall cycles.
  task automatic fetch_one(input int unsigned delay, input logic [31:0] word,
                           input int unsigned stalls, input string tag);
    for (int i = 0; i <= int'(delay); i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s fetch_wait: req=%b addr=%h valid=%b, need req=1 addr=%h valid=0",
                 tag, imem_req, imem_addr, instr_valid, m_pc);
      end
      stall = 1'($urandom_range(0, 1));
      if (i < int'(delay)) begin
        imem_rdata = $urandom;
        tick();
      end
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    m_instr = word;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word || pc !== m_pc ||
        imm !== word[15:0] || pc_plus4 !== m_pc + 32'd4) begin
      errors++;
      $display("FAIL %s fetched: valid=%b req=%b instr=%h pc=%h imm=%h pc4=%h, need 1 0 %h %h %h %h",
               tag, instr_valid, imem_req, instr, pc, imm, pc_plus4,
               word, m_pc, word[15:0], m_pc + 32'd4);
    end
    for (int s = 0; s < int'(stalls); s++) begin
      stall = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      jr = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1));
      br_taken = 1'($urandom_range(0, 1));
      jr_target = $urandom;
      br_offset = $urandom;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== m_instr || pc !== m_pc || fault !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_hold: valid=%b req=%b instr=%h pc=%h fault=%b, need 1 0 %h %h 0",
                 tag, instr_valid, imem_req, instr, pc, fault, m_instr, m_pc);
      end
    end
    stall = 1'b0; imem_ack = 1'b0; jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
  endtask

  // Retire the held instruction with the given redirect inputs.
  task automatic retire(input logic jr_i, input logic [31:0] tgt, input logic j_i,
                        input logic b_i, input logic [31:0] off, input string tag);
    logic [31:0] nxt;
    nxt = ref_next(m_pc, m_instr, jr_i, tgt, j_i, b_i, off);
    jr = jr_i; jr_target = tgt; jump = j_i; br_taken = b_i; br_offset = off; stall = 1'b0;
    tick();
    jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
    jr_target = $urandom; br_offset = $urandom;
    m_pc = nxt;
    if (nxt[1:0] != 2'b00) m_fault = 1'b1;
    checks++;
    if (m_fault) begin
      if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== nxt) begin
        errors++;
        $display("FAIL %s retire_fault: fault=%b req=%b valid=%b pc=%h, need 1 0 0 %h",
                 tag, fault, imem_req, instr_valid, pc, nxt);
      end
    end else begin
      if (imem_req !== 1'b1 || imem_addr !== nxt || instr_valid !== 1'b0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL %s retire: req=%b addr=%h valid=%b fault=%b, need 1 %h 0 0",
                 tag, imem_req, imem_addr, instr_valid, fault, nxt);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== RESET_PC || imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0 || instr !== 32'h0) begin
        errors++;
        $display("FAIL reset_values: pc=%h req=%b valid=%b fault=%b instr=%h, need %h 0 0 0 0",
                 pc, imem_req, instr_valid, fault, instr, RESET_PC);
      end
    end
    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL startup_fetch: req=%b addr=%h valid=%b, need 1 00003000 0",
               imem_req, imem_addr, instr_valid);
    end
    m_pc = RESET_PC; m_instr = '0; m_fault = 1'b0;
  endtask

  task automatic test_sequential();
    int unsigned t_prev;
    do_reset();
    t_prev = cyc;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (imem_addr !== 32'h0000_3000 + 32'(4 * k) || (k > 0 && cyc - t_prev != 2)) begin
        errors++;
        $display("FAIL seq_addr: addr=%h after %0d cycles, need %h after 2",
                 imem_addr, cyc - t_prev, 32'h0000_3000 + 32'(4 * k));
      end
      t_prev = cyc;
      fetch_one(0, 32'h2008_0001, 0, "seq");
      retire(1'b0, '0, 1'b0, 1'b0, '0, "seq");
    end
  endtask

  task automatic test_wait_stall();
    do_reset();
    fetch_one(3, $urandom, 4, "wait");
    retire(1'b0, '0, 1'b0, 1'b0, '0, "wait");
    fetch_one(2, $urandom, 0, "wait2");
    retire(1'b0, '0, 1'b0, 1'b0, '0, "wait2");
  endtask

  task automatic test_branch_jump();
    do_reset();
    fetch_one(0, $urandom, 0, "br"); retire(1'b0, '0, 1'b0, 1'b0, '0, "br");
    fetch_one(0, $urandom, 0, "br"); retire(1'b0, '0, 1'b0, 1'b0, '0, "br");
    fetch_one(0, $urandom, 0, "br"); retire(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFE, "br");
    checks++;
    if (imem_addr !== 32'h0000_3004) begin
      errors++;
      $display("FAIL branch_back: addr=%h, need 00003004", imem_addr);
    end
    do_reset();
    fetch_one(0, 32'h0800_0C10, 0, "jmp");
    retire(1'b0, '0, 1'b1, 1'b1, 32'h0000_0010, "jmp");
    checks++;
    if (imem_addr !== 32'h0000_3040) begin
      errors++;
      $display("FAIL jump_wins: addr=%h, need 00003040", imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_one(0, $urandom, 0, "wrap");
    retire(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, "wrap");
    fetch_one(1, $urandom, 0, "wrap");
    checks++;
    if (pc_plus4 !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc4_wrap: pc_plus4=%h, need 00000000", pc_plus4);
    end
    retire(1'b0, '0, 1'b0, 1'b0, '0, "wrap");
    fetch_one(0, $urandom, 0, "wrap0");
  endtask

  task automatic test_misaligned();
    do_reset();
    fetch_one(1, $urandom, 1, "mis");
    retire(1'b1, 32'h0000_3002, 1'b0, 1'b0, '0, "mis");
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      jr = 1'($urandom_range(0, 1));
      jr_target = $urandom & 32'hFFFF_FFFC;
      tick();
      checks++;
      if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0000_3002) begin
        errors++;
        $display("FAIL halt_hold: fault=%b req=%b valid=%b pc=%h, need 1 0 0 00003002",
                 fault, imem_req, instr_valid, pc);
      end
    end
    do_reset();
    checks++;
    if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL fault_clear: fault=%b req=%b addr=%h, need 0 1 00003000",
               fault, imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fetch_one(0, $urandom, 0, "ar");
      retire(1'b0, '0, 1'b0, 1'b0, '0, "ar");
    end
    tick(); tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3010) begin
      errors++;
      $display("FAIL ar_pending: req=%b addr=%h, need 1 00003010", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== RESET_PC || instr !== 32'h0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL ar_async: req=%b valid=%b pc=%h instr=%h fault=%b, need 0 0 %h 0 0",
               imem_req, instr_valid, pc, instr, fault, RESET_PC);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL ar_late_ack: instr=%h valid=%b req=%b, need 0 0 0", instr, instr_valid, imem_req);
    end
    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_refetch: req=%b addr=%h instr=%h valid=%b, need 1 %h 0 0",
               imem_req, imem_addr, instr, instr_valid, RESET_PC);
    end
  endtask

  task automatic test_random();
    int unsigned kind;
    int o;
    logic [31:0] off;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      fetch_one($urandom_range(0, 3), $urandom, $urandom_range(0, 2), "rnd");
      kind = $urandom_range(0, 5);
      o = int'($urandom_range(0, 16)) - 8;
      off = 32'(o);
      case (kind)
        0: retire(1'b0, '0, 1'b0, 1'b0, '0, "rnd_seq");
        1: retire(1'b0, '0, 1'b0, 1'b1, off, "rnd_br");
        2: retire(1'b0, '0, 1'b1, 1'b0, off, "rnd_j");
        3: retire(1'b1, $urandom & 32'hFFFF_FFFC, 1'b0, 1'b0, off, "rnd_jr");
        4: retire(1'b0, '0, 1'b1, 1'b1, off, "rnd_jbr");
        default: retire(1'b1, $urandom & 32'hFFFF_FFFC, 1'b1, 1'b1, off, "rnd_all");
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_stall();
    test_branch_jump();
    test_wrap();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
